layer2_mac_engine: RTL and testbench

- Parametrised fixed-point matrix-vector multiply-accumulate engine for the second (fully connected) layer.
- Takes an N_IN-element activation vector as a valid/ready stream and multiplies it by an on-block N_IN x N_OUT weight memory.
- Accumulates N_OUT results with saturation and streams them out with valid/ready for the sigmoid stage.
- Generalises the hard-wired 16-bit Q8.8 layer-2 path: configurable width, fraction bits and dimensions, plus handshakes and overflow detection.

---
 rtl/layer2_mac_engine.sv | 213 +++++++++++++++++++++
 tb/tb_layer2_mac_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer2_mac_engine.sv
// layer2_mac_engine: fixed-point matrix-vector multiply-accumulate engine for
// the fully connected second layer. Activations arrive one element at a time;
// each element is multiplied against one row of the on-block weight memory
// and accumulated, with saturation, into N_OUT results that are then streamed
// out with valid/ready.
// Optional build macro BIAS_INIT_EN: accumulators start from bias words stored
// at weight addresses N_IN*N_OUT+j instead of from zero.
module layer2_mac_engine #(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int N_IN     = 16,
  parameter int N_OUT    = 10,
  parameter int W_ADDR_W = 8,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                w_we,
  input  logic [W_ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_index,
  output logic                busy,
  output logic                done,
  output logic                sat_flag
);

  localparam int MCNT_W = $clog2(N_OUT + 1);
  localparam int I_W    = $clog2(N_IN + 1);
  localparam logic [MCNT_W-1:0] M_LAST = MCNT_W'(N_OUT);
  localparam logic [I_W-1:0]    I_LAST = I_W'(N_IN - 1);
  localparam logic [IDX_W-1:0]  K_LAST = IDX_W'(N_OUT - 1);
  localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, WAIT_IN, MAC, OUT, DONE} state_t;

  state_t state, state_nx;
  logic [I_W-1:0]      i_cnt;
  logic [MCNT_W-1:0]   m_cnt;
  logic [IDX_W-1:0]    k_cnt;
  logic [W_ADDR_W-1:0] rd_addr;
  logic                vld_p1;
  logic [MCNT_W-1:0]   j_p1;

  logic signed [DATA_W-1:0] mem [2**W_ADDR_W];
  logic signed [DATA_W-1:0] x_p0;
  logic signed [DATA_W-1:0] w_p1;
  logic signed [DATA_W-1:0] acc [N_OUT];
  logic signed [DATA_W-1:0] term, acc_nx;
  logic                     term_sat, add_sat;
  logic                     load_ok, go;

  // Product scaled back to Q.FRAC_W (floor), clamped to DATA_W; MSB = clamped.
  function automatic logic [DATA_W:0] sat_mul_shift(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] prod;
    prod = a * b;
    prod = prod >>> FRAC_W;
    if (prod[2*DATA_W-1:DATA_W-1] == '0 || prod[2*DATA_W-1:DATA_W-1] == '1)
      return {1'b0, prod[DATA_W-1:0]};
    return {1'b1, prod[2*DATA_W-1] ? D_MIN : D_MAX};
  endfunction

  // Saturating DATA_W add; MSB = clamped.
  function automatic logic [DATA_W:0] sat_add(input logic signed [DATA_W-1:0] a,
                                              input logic signed [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] == sum[DATA_W-1])
      return {1'b0, sum[DATA_W-1:0]};
    return {1'b1, sum[DATA_W] ? D_MIN : D_MAX};
  endfunction

  assign go      = (state == IDLE) && start;
  assign load_ok = (state == IDLE) && w_we && !start;

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = WAIT_IN;
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = MAC;
      end
      MAC: begin
        if (m_cnt == M_LAST) state_nx = (i_cnt == I_LAST) ? OUT : WAIT_IN;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready && k_cnt == K_LAST) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  assign out_data  = out_valid ? acc[k_cnt] : '0;
  assign out_index = out_valid ? k_cnt : '0;

  // Control: state, element/read/output counters, read-valid pipe, sticky flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      i_cnt    <= '0;
      m_cnt    <= '0;
      k_cnt    <= '0;
      rd_addr  <= '0;
      vld_p1   <= 1'b0;
      j_p1     <= '0;
      sat_flag <= 1'b0;
    end else begin
      state  <= state_nx;
      vld_p1 <= (state == MAC) && (m_cnt != M_LAST);
      j_p1   <= m_cnt;
      if (vld_p1 && (term_sat || add_sat)) sat_flag <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            i_cnt    <= '0;
            m_cnt    <= '0;
            k_cnt    <= '0;
            rd_addr  <= '0;
            sat_flag <= 1'b0;
          end
        end
        MAC: begin
          if (m_cnt != M_LAST) begin
            m_cnt   <= m_cnt + 1'b1;
            rd_addr <= rd_addr + 1'b1;
          end else begin
            m_cnt <= '0;
            k_cnt <= '0;
            if (i_cnt != I_LAST) i_cnt <= i_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Weight memory: write port for off-chip loading, synchronous read port.
  always_ff @(posedge clk) begin
    if (load_ok) mem[w_addr] <= w_data;
    // ---- stage p0 -> p1: weight read for the row element being issued ----
    w_p1 <= mem[rd_addr];
  end

  // Activation latch on input handshake; held for the whole MAC pass.
  always_ff @(posedge clk) begin
    if (state == WAIT_IN && in_valid) x_p0 <= in_data;
  end

  // ---- stage p1: multiply, scale, saturate, accumulate ----
  // Arithmetic for the accumulator addressed by the read pipeline.
  always_comb begin
    {term_sat, term}  = sat_mul_shift(w_p1, x_p0);
    {add_sat, acc_nx} = sat_add(acc[j_p1], term);
  end

`ifdef BIAS_INIT_EN
  localparam logic [W_ADDR_W-1:0] BIAS_LO = W_ADDR_W'(N_IN * N_OUT);
  localparam logic [W_ADDR_W-1:0] BIAS_HI = W_ADDR_W'(N_IN * N_OUT + N_OUT);
  logic signed [DATA_W-1:0] bias [N_OUT];
  logic [W_ADDR_W-1:0]      bias_idx;
  assign bias_idx = w_addr - BIAS_LO;

  // Shadow copy of the bias words so start can preload every accumulator at once.
  always_ff @(posedge clk) begin
    if (load_ok && w_addr >= BIAS_LO && w_addr < BIAS_HI) bias[bias_idx] <= w_data;
  end
`endif

  // Accumulators: preload on start, update one entry per valid MAC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else if (go) begin
`ifdef BIAS_INIT_EN
      for (int j = 0; j < N_OUT; j++) acc[j] <= bias[j];
`else
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
`endif
    end else if (vld_p1) begin
      acc[j_p1] <= acc_nx;
    end
  end

endmodule

// File: tb/tb_layer2_mac_engine.sv
// Directed self-checking bench for layer2_mac_engine (default parameters).
// Honors BIAS_INIT_EN in the bias scenario's expected values.
module tb_layer2_mac_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [7:0]  w_addr;
  logic [15:0] w_data;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_index;
  logic        busy;
  logic        done;
  logic        sat_flag;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] xv   [16];
  logic [15:0] expv [10];

  layer2_mac_engine dut (
    .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_all(input logic [15:0] w);
    w_we = 1'b1;
    for (int a = 0; a < 160; a++) begin
      w_addr = 8'(a);
      w_data = w;
      @(negedge clk);
    end
    w_we = 1'b0;
  endtask

  task automatic load_ident();
    w_we = 1'b1;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 10; j++) begin
        w_addr = 8'(i * 10 + j);
        w_data = (j == i % 10) ? 16'h0100 : 16'h0000;
        @(negedge clk);
      end
    w_we = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Stream the first n entries of xv, one handshake each.
  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      int cnt;
      cnt      = 0;
      in_data  = xv[i];
      in_valid = 1'b1;
      while (!in_ready && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      if (!in_ready) chk("in_ready_timeout", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Drain all results against expv; optional 5-cycle stall at index 3.
  task automatic collect(input string tag, input bit stall, input bit exp_sat, input bit chk_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_first_valid"}, out_valid, 1);
    if (chk_lat) chk({tag, "_latency"}, lat, 12);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), out_valid, 1);
      chk($sformatf("%s_data%0d", tag, k), out_data, expv[k]);
      chk($sformatf("%s_index%0d", tag, k), out_index, k);
      if (stall && k == 3) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk({tag, "_stall_valid"}, out_valid, 1);
          chk({tag, "_stall_data"}, out_data, expv[3]);
          chk({tag, "_stall_index"}, out_index, 3);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_sat"}, sat_flag, exp_sat);
    @(negedge clk);
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_valid_after"}, out_valid, 0);
    chk({tag, "_sat_held"}, sat_flag, exp_sat);
  endtask

  task automatic run_basic(input string tag, input bit chk_lat);
    for (int i = 0; i < 16; i++) xv[i] = 16'h0200;
    for (int j = 0; j < 10; j++) expv[j] = 16'h2000;
    start_run();
    send(16);
    collect(tag, 1'b0, 1'b0, chk_lat);
  endtask

  initial begin
    reset = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0; start = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_flag, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1.0 weights, 2.0 inputs: 16 * 2.0 = 32.0
    load_all(16'h0100);
    run_basic("unit", 1'b1);

    // Positive and negative overflow clamp
    load_all(16'h7FFF);
    for (int i = 0; i < 16; i++) xv[i] = 16'h7FFF;
    for (int j = 0; j < 10; j++) expv[j] = 16'h7FFF;
    start_run(); send(16); collect("satpos", 1'b0, 1'b1, 1'b0);
    load_all(16'h8000);
    for (int j = 0; j < 10; j++) expv[j] = 16'h8000;
    start_run(); send(16); collect("satneg", 1'b0, 1'b1, 1'b0);

    // Identity-like: y[j] = sum of i (0..15) with i%10 == j, so j<6 picks j and j+10
    load_ident();
    for (int i = 0; i < 16; i++) xv[i] = 16'(i << 8);
    expv[0] = 16'h0A00; expv[1] = 16'h0C00; expv[2] = 16'h0E00; expv[3] = 16'h1000;
    expv[4] = 16'h1200; expv[5] = 16'h1400; expv[6] = 16'h0600; expv[7] = 16'h0700;
    expv[8] = 16'h0800; expv[9] = 16'h0900;
    start_run(); send(16); collect("ident", 1'b1, 1'b0, 1'b0);

    // Abort mid-run with reset, then rerun cleanly
    load_all(16'h0100);
    for (int i = 0; i < 16; i++) xv[i] = 16'h0200;
    start_run(); send(5);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_basic("rerun", 1'b0);

    // start and weight write while busy are ignored
    for (int i = 0; i < 16; i++) xv[i] = 16'h0200;
    for (int j = 0; j < 10; j++) expv[j] = 16'h2000;
    start_run();
    start = 1'b1; w_we = 1'b1; w_addr = 8'd0; w_data = 16'h7FFF;
    @(negedge clk);
    start = 1'b0; w_we = 1'b0;
    chk("ign_busy", busy, 1);
    chk("ign_in_ready", in_ready, 1);
    send(16);
    collect("ignore", 1'b0, 1'b0, 1'b0);
    run_basic("oldw", 1'b0);

    // Bias words above the weight matrix
    w_we = 1'b1;
    for (int j = 0; j < 10; j++) begin
      w_addr = 8'(160 + j);
      w_data = 16'(16'h0100 * j);
      @(negedge clk);
    end
    w_we = 1'b0;
    for (int i = 0; i < 16; i++) xv[i] = 16'h0200;
    for (int j = 0; j < 10; j++) begin
`ifdef BIAS_INIT_EN
      expv[j] = 16'(16'h2000 + 16'h0100 * j);
`else
      expv[j] = 16'h2000;
`endif
    end
    start_run(); send(16); collect("bias", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
